// File: rtl/somador_serial.sv
// -----------------------------------------------------------------------------
// somador_serial
//   Multi-cycle adder/subtractor. The WIDTH-bit operands are consumed CHUNK
//   bits per clock, least-significant chunk first. The carry between chunks
//   lives in a flop, so the longest combinational path is one CHUNK-bit add.
//   The result appears in output registers together with a one-cycle done.
//
// Parameters
//   WIDTH     operand/result width, a multiple of CHUNK
//   CHUNK     bits added per RUN cycle (1..WIDTH)
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high; aborts any operation, clears outputs
//   start     request, accepted while busy = 0
//   sub       0: A + B + cin, 1: A + ~B + 1 (sampled with start)
//   inputA    operand A (sampled with start)
//   inputB    operand B (sampled with start)
//   cin       carry-in for add mode (sampled with start)
//   output_s  result
//   cout      carry out of the MSB (subtract: 1 means no borrow)
//   overflow  signed overflow
//   zero      output_s == 0
//   busy      operation in progress (state RUN)
//   done      one-cycle pulse, result registers just loaded (state DONE)
// -----------------------------------------------------------------------------
module somador_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             cin,
  output logic [WIDTH-1:0] output_s,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry_reg;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK:0]   chunk_res;
  logic [CHUNK-1:0] sum_chunk;
  logic             carry_out;
  logic             ovf_chunk;

  // One chunk of the ripple: {carry_out, sum} = x + y + c.
  function automatic logic [CHUNK:0] add_chunk(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             c
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  // The carry into the top bit is recovered from that bit's sum and inputs,
  // so no extra flop is needed to track it.
  function automatic logic signed_ovf(
    input logic x_msb,
    input logic y_msb,
    input logic s_msb,
    input logic c_out
  );
    logic c_into_msb;
    c_into_msb = x_msb ^ y_msb ^ s_msb;
    return c_into_msb ^ c_out;
  endfunction

  assign accept     = start && (state != RUN);
  assign last_chunk = (state == RUN) && (count == CNT_W'(N - 1));

  always_comb begin
    chunk_res = add_chunk(a_sh[CHUNK-1:0], b_sh[CHUNK-1:0], carry_reg);
    sum_chunk = chunk_res[CHUNK-1:0];
    carry_out = chunk_res[CHUNK];
    ovf_chunk = signed_ovf(a_sh[CHUNK-1], b_sh[CHUNK-1], sum_chunk[CHUNK-1],
                           carry_out);
    // New chunk enters at the top; after N shifts chunk 0 sits at bit 0.
    res_next  = (res_sh >> CHUNK) | (WIDTH'(sum_chunk) << (WIDTH - CHUNK));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = last_chunk ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: both flags come straight from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand capture and chunk-serial datapath. These registers are always
  // reloaded on accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh      <= inputA;
      b_sh      <= sub ? ~inputB : inputB;
      carry_reg <= sub ? 1'b1 : cin;
      count     <= '0;
    end else if (state == RUN) begin
      a_sh      <= a_sh >> CHUNK;
      b_sh      <= b_sh >> CHUNK;
      res_sh    <= res_next;
      carry_reg <= carry_out;
      count     <= count + 1'b1;
    end
  end

  // Result registers: loaded on the edge that enters DONE, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      output_s <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (last_chunk) begin
      output_s <= res_next;
      cout     <= carry_out;
      overflow <= ovf_chunk;
      zero     <= (res_next == '0);
    end
  end

endmodule

// File: tb/tb_somador_serial.sv
// -----------------------------------------------------------------------------
// tb_somador_serial
//   Directed bench for somador_serial: default 32/4 instance plus two 8-bit
//   instances (CHUNK=1 and CHUNK=8) sharing one set of inputs.
// -----------------------------------------------------------------------------
module tb_somador_serial;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // 32-bit / CHUNK 4 instance
  logic        st, sb, ci;
  logic [31:0] ia, ib;
  logic [31:0] s32;
  logic        co32, ov32, z32, bz32, dn32;

  // 8-bit instances, shared stimulus
  logic        st8, sb8, ci8;
  logic [7:0]  ia8, ib8;
  logic [7:0]  s_c1, s_c8;
  logic        co_c1, ov_c1, z_c1, bz_c1, dn_c1;
  logic        co_c8, ov_c8, z_c8, bz_c8, dn_c8;

  int checks = 0;
  int fails  = 0;

  somador_serial #(.WIDTH(32), .CHUNK(4)) u32 (
    .clk(clk), .reset(reset), .start(st), .sub(sb), .inputA(ia), .inputB(ib),
    .cin(ci), .output_s(s32), .cout(co32), .overflow(ov32), .zero(z32),
    .busy(bz32), .done(dn32)
  );

  somador_serial #(.WIDTH(8), .CHUNK(1)) u8c1 (
    .clk(clk), .reset(reset), .start(st8), .sub(sb8), .inputA(ia8),
    .inputB(ib8), .cin(ci8), .output_s(s_c1), .cout(co_c1),
    .overflow(ov_c1), .zero(z_c1), .busy(bz_c1), .done(dn_c1)
  );

  somador_serial #(.WIDTH(8), .CHUNK(8)) u8c8 (
    .clk(clk), .reset(reset), .start(st8), .sub(sb8), .inputA(ia8),
    .inputB(ib8), .cin(ci8), .output_s(s_c8), .cout(co_c8),
    .overflow(ov_c8), .zero(z_c8), .busy(bz_c8), .done(dn_c8)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input string tag, input logic [31:0] pa,
                       input logic [31:0] pb, input logic psub,
                       input logic pcin, input logic [31:0] es,
                       input logic ec, input logic ev, input logic ez);
    int n;
    ia = pa; ib = pb; sb = psub; ci = pcin; st = 1'b1;
    tick();
    st = 1'b0;
    n = 1;
    while (!dn32 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, n, 9);
    check({tag, ".done"}, {31'd0, dn32}, 32'd1);
    check({tag, ".busy"}, {31'd0, bz32}, 32'd0);
    check({tag, ".sum"}, s32, es);
    check({tag, ".cout"}, {31'd0, co32}, {31'd0, ec});
    check({tag, ".ovf"}, {31'd0, ov32}, {31'd0, ev});
    check({tag, ".zero"}, {31'd0, z32}, {31'd0, ez});
    tick();
    check({tag, ".done_drop"}, {31'd0, dn32}, 32'd0);
  endtask

  // Independent 8-bit reference, packed as {ovf, cout, zero, sum}.
  function automatic logic [10:0] model8(input logic [7:0] pa,
                                         input logic [7:0] pb,
                                         input logic psub, input logic pcin);
    logic [8:0] full;
    logic       v;
    if (psub) begin
      full = {1'b0, pa} + {1'b0, ~pb} + 9'd1;
      v    = (pa[7] != pb[7]) && (full[7] != pa[7]);
    end else begin
      full = {1'b0, pa} + {1'b0, pb} + {8'd0, pcin};
      v    = (pa[7] == pb[7]) && (full[7] != pa[7]);
    end
    return {v, full[8], (full[7:0] == 8'd0), full[7:0]};
  endfunction

  task automatic run8(input logic [7:0] pa, input logic [7:0] pb,
                      input logic psub, input logic pcin);
    int n, t1, t8;
    logic [10:0] r1, r8, exp;
    exp = model8(pa, pb, psub, pcin);
    ia8 = pa; ib8 = pb; sb8 = psub; ci8 = pcin; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    n = 1; t1 = 0; t8 = 0; r1 = '0; r8 = '0;
    while ((t1 == 0 || t8 == 0) && n < 30) begin
      if (dn_c1 && t1 == 0) begin t1 = n; r1 = {ov_c1, co_c1, z_c1, s_c1}; end
      if (dn_c8 && t8 == 0) begin t8 = n; r8 = {ov_c8, co_c8, z_c8, s_c8}; end
      if (t1 == 0 || t8 == 0) begin
        tick();
        n++;
      end
    end
    check("w8c1.latency", t1, 9);
    check("w8c8.latency", t8, 2);
    check("w8c1.result", {21'd0, r1}, {21'd0, exp});
    check("w8c8.result", {21'd0, r8}, {21'd0, exp});
    tick();
  endtask

  initial begin
    int pulses, cnt1, cnt8, prev1, prev8;
    logic [31:0] got_s;
    logic        got_c, got_v;

    reset = 1'b1;
    st = 1'b0; sb = 1'b0; ci = 1'b0; ia = '0; ib = '0;
    st8 = 1'b0; sb8 = 1'b0; ci8 = 1'b0; ia8 = '0; ib8 = '0;
    tick();
    tick();
    check("rst.sum", s32, 32'd0);
    check("rst.flags", {27'd0, co32, ov32, z32, bz32, dn32}, 32'd0);
    check("rst.w8", {12'd0, s_c1, s_c8, bz_c1, dn_c1, bz_c8, dn_c8}, 32'd0);
    reset = 1'b0;
    tick();

    run32("add_small", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0,
          32'h0000_0008, 1'b0, 1'b0, 1'b0);
    run32("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
          32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run32("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
          32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run32("sub_neg",   32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1,
          32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run32("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0,
          32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Second start mid-RUN and operand churn must not disturb the result.
    ia = 32'h1234_5678; ib = 32'h1111_1111; sb = 1'b0; ci = 1'b1; st = 1'b1;
    tick();
    pulses = 0; got_s = '0; got_c = 1'b0; got_v = 1'b0;
    for (int i = 1; i < 20; i++) begin
      ia = $urandom; ib = $urandom; sb = 1'($urandom); ci = 1'($urandom);
      st = (i == 3);
      tick();
      if (dn32) begin
        pulses++;
        got_s = s32; got_c = co32; got_v = ov32;
      end
    end
    st = 1'b0;
    check("busy_start.pulses", pulses, 1);
    check("busy_start.sum", got_s, 32'h2345_678A);
    check("busy_start.cv", {30'd0, got_c, got_v}, 32'd0);

    // Reset in the middle of RUN aborts without a done pulse.
    ia = 32'h0000_0011; ib = 32'h0000_0022; sb = 1'b0; ci = 1'b0; st = 1'b1;
    tick();
    st = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst.busy_done", {30'd0, bz32, dn32}, 32'd0);
    check("mid_rst.sum", s32, 32'd0);
    check("mid_rst.flags", {29'd0, co32, ov32, z32}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dn32) pulses++;
    end
    check("mid_rst.no_done", pulses, 0);
    run32("after_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
          32'h0001_0000, 1'b0, 1'b0, 1'b0);

    // 8-bit sweep against the reference model.
    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    run8(8'h80, 8'h01, 1'b1, 1'b0);
    run8(8'h03, 8'h05, 1'b1, 1'b1);
    run8(8'h40, 8'h3F, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    // start held high: one done per N+1 cycles on each instance.
    tick(); tick();
    ia8 = 8'h21; ib8 = 8'h12; sb8 = 1'b0; ci8 = 1'b0; st8 = 1'b1;
    cnt1 = 0; cnt8 = 0; prev1 = -1; prev8 = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (dn_c1) begin
        if (prev1 >= 0) check("b2b.c1.period", n - prev1, 9);
        check("b2b.c1.sum", {24'd0, s_c1}, 32'h33);
        prev1 = n;
        cnt1++;
      end
      if (dn_c8) begin
        if (prev8 >= 0) check("b2b.c8.period", n - prev8, 2);
        prev8 = n;
        cnt8++;
      end
    end
    st8 = 1'b0;
    check("b2b.c1.count", cnt1, 4);
    check("b2b.c8.count", cnt8, 20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/somador_serial.md
# somador_serial

Parametrised multi-cycle adder/subtractor for the MIPS datapath. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a registered carry flop between chunks. This trades latency for area compared with a full-width combinational adder. Results are held in output registers and flagged with a one-cycle `done`. The block serves multi-cycle datapath units (e.g. the multiply/divide sequencer) that can tolerate a fixed latency.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH
- (derived) N = WIDTH/CHUNK, number of RUN cycles
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when `busy`=0
- sub  input  1  0: A+B+cin; 1: A+~B+1 (cin ignored); sampled with start
- inputA  input  WIDTH  operand A, sampled with start
- inputB  input  WIDTH  operand B, sampled with start
- cin  input  1  carry-in for add mode, sampled with start
- output_s  output  WIDTH  result
- cout  output  1  carry out of MSB (sub mode: 1 = no borrow)
- overflow  output  1  signed overflow
- zero  output  1  output_s == 0
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result registers just updated

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1:
  - Capture A into a shift register and B (inverted if sub) into a shift register.
  - Set carry_reg = sub ? 1 : cin; count = 0.
  - Go to RUN.
- IDLE or DONE, start=0: go to / stay IDLE.
- RUN, each cycle:
  - Add the low CHUNK bits of A, B and carry_reg.
  - Shift the sum chunk into the top of the result shift register.
  - Shift A and B right by CHUNK and update carry_reg.
  - count++.
- RUN, after the chunk with count == N-1: go to DONE.
- On entry to DONE (same edge), load the output registers:
  - output_s = assembled sum.
  - cout = final carry.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0).
- Output registers change only on entry to DONE; otherwise they hold their last value.
- start while busy=1 is ignored. Operand, sub and cin changes after capture have no effect.
- Reset, any cycle including mid-RUN:
  - State goes to IDLE; the operation is aborted and done is not pulsed.
  - output_s, cout, overflow, zero, busy and done all read 0.
- N=1 (CHUNK=WIDTH) is legal: one RUN cycle.

## Timing
- Start sampled high at edge k (busy=0):
  - busy=1 during cycles k+1 … k+N.
  - Outputs update at edge k+N; done=1 and busy=0 during cycle k+N+1.
- Latency from start edge to the done cycle: N+1 edges (9 for the defaults).
- busy is a registered state decode: 1 iff state == RUN.
- done is a registered state decode: 1 iff state == DONE.
- Back-to-back: start=1 during the DONE cycle is accepted. Throughput is one result per N+1 cycles.
- start held continuously high: a new operation starts every N+1 cycles.
- Critical path: one CHUNK-bit add plus carry register; no WIDTH-wide carry chain.

## Test plan
- Defaults; A=0x00000005, B=0x00000003, cin=0, sub=0 -> 9 edges after start: done=1, output_s=0x00000008, cout=0, overflow=0, zero=0.
- A=0xFFFFFFFF, B=0x00000001, add -> output_s=0x00000000, cout=1, zero=1, overflow=0. A=0x7FFFFFFF, B=0x00000001 -> output_s=0x80000000, overflow=1, cout=0.
- sub=1, A=3, B=5, cin=1 (ignored) -> output_s=0xFFFFFFFE, cout=0, overflow=0. sub=1, A=0x80000000, B=1 -> output_s=0x7FFFFFFF, overflow=1, cout=1.
- start pulsed again at RUN cycle 3, with inputA/inputB changed each RUN cycle -> ignored; result matches the operands captured at the original start; exactly one done pulse.
- reset asserted for one cycle at RUN cycle 4 -> next cycle busy=0, done=0, all outputs 0, no done pulse follows. A fresh start then completes normally in 9 edges.
- Parameter sweep WIDTH=8 with CHUNK=1, 8; random operands vs. reference model -> results match; done at N+1 edges (9 and 2 respectively); back-to-back starts yield one done per N+1 cycles.
